// File: rtl/pc_mux_pkg.sv
// Shared constants for the fetch-stage next-PC selector.
package pc_mux_pkg;

  localparam int               XLEN          = 32;
  localparam logic [XLEN-1:0]  RESET_VECTOR  = 32'h0000_0000;
  localparam logic             PC_SEL_SEQ    = 1'b0;
  localparam logic             PC_SEL_BRANCH = 1'b1;

  // Instructions are word aligned, so any set bit in [1:0] is a fault.
  function automatic logic isMisaligned(input logic [1:0] lowBits);
    return lowBits != 2'b00;
  endfunction

endpackage

// File: rtl/pc_mux_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_mux.sv
// Next-PC selector: combinational mux to imem/PC register, plus registered
// copy, flush pulse, redirect counter and alignment flag.
module pc_mux #(
  parameter int              XLEN         = pc_mux_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = pc_mux_pkg::RESET_VECTOR,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  pc_branch,
  input  logic             pc_select,
  output logic [XLEN-1:0]  pc_out,
  output logic             pc_misaligned,
  output logic [XLEN-1:0]  pc_q,
  output logic             redirect_q,
  output logic [CNT_W-1:0] redirect_count
);

  import pc_mux_pkg::*;

  logic takeBranch;
  logic [XLEN-1:0] pcReg_q;
  logic redirectReg_q;

  // Written as if/else so an unknown select falls back to the sequential PC.
  always_comb begin
    takeBranch = 1'b0;
    pc_out     = pc_in;
    if (pc_select == PC_SEL_BRANCH) begin
      takeBranch = 1'b1;
      pc_out     = pc_branch;
    end
  end

  assign pc_misaligned = isMisaligned(pc_out[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcReg_q       <= RESET_VECTOR;
      redirectReg_q <= 1'b0;
    end else begin
      pcReg_q       <= pc_out;
      redirectReg_q <= takeBranch;
    end
  end

  assign pc_q       = pcReg_q;
  assign redirect_q = redirectReg_q;

  sat_counter #(
    .WIDTH (CNT_W)
  ) uRedirectCount (
    .clk   (clk),
    .rst   (rst),
    .inc   (takeBranch),
    .count (redirect_count)
  );

endmodule

// File: tb/tb_pc_mux.sv
// Directed bench for pc_mux: a default instance and a 2-bit-counter instance
// share the same stimulus.
module tb_pc_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pcIn = '0;
  logic [31:0] pcBranch = '0;
  logic        pcSelect = 1'b0;

  logic [31:0] pcOut, pcQ;
  logic        pcMis, redirectQ;
  logic [15:0] redirectCount;

  logic [31:0] satPcOut, satPcQ;
  logic        satPcMis, satRedirectQ;
  logic [1:0]  satRedirectCount;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  pc_mux dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pcIn),
    .pc_branch      (pcBranch),
    .pc_select      (pcSelect),
    .pc_out         (pcOut),
    .pc_misaligned  (pcMis),
    .pc_q           (pcQ),
    .redirect_q     (redirectQ),
    .redirect_count (redirectCount)
  );

  pc_mux #(.CNT_W(2)) dutSat (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pcIn),
    .pc_branch      (pcBranch),
    .pc_select      (pcSelect),
    .pc_out         (satPcOut),
    .pc_misaligned  (satPcMis),
    .pc_q           (satPcQ),
    .redirect_q     (satRedirectQ),
    .redirect_count (satRedirectCount)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] inVal, input logic [31:0] brVal, input logic sel);
    pcIn     = inVal;
    pcBranch = brVal;
    pcSelect = sel;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Combinational path, independent of the clock
    applyStimulus(32'h0000_0010, 32'h0000_0080, 1'b0);
    #1;
    checkOutput("seqOut", pcOut, 32'h0000_0010);
    checkOutput("seqMis", pcMis, 1'b0);
    pcSelect = 1'b1;
    #1;
    checkOutput("brOut", pcOut, 32'h0000_0080);
    checkOutput("brMis", pcMis, 1'b0);
    applyStimulus(32'h0040_0000, 32'h0080_0000, 1'b0);
    #1;
    checkOutput("newSeqOut", pcOut, 32'h0040_0000);
    pcSelect = 1'b1;
    #1;
    checkOutput("newBrOut", pcOut, 32'h0080_0000);

    // Reset for two edges; combinational output keeps tracking inputs
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(32'h0000_0124, 32'h0080_0000, 1'b0);
    #1;
    checkOutput("rstOutTrack", pcOut, 32'h0000_0124);
    repeat (2) tick();
    checkOutput("rstPcQ", pcQ, 32'h0000_0000);
    checkOutput("rstRedir", redirectQ, 1'b0);
    checkOutput("rstCnt", redirectCount, 16'd0);
    checkOutput("rstSatCnt", satRedirectCount, 2'd0);

    // Six branch cycles: full counter counts, 2-bit counter saturates at 3
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'h0000_0124, 32'h0080_0000, 1'b1);
    for (int n = 1; n <= 6; n++) begin
      tick();
      checkOutput("brPcQ", pcQ, 32'h0080_0000);
      checkOutput("brRedir", redirectQ, 1'b1);
      checkOutput("brCnt", redirectCount, 16'(n));
      checkOutput("satCnt", satRedirectCount, (n > 3) ? 2'd3 : 2'(n));
    end

    // Sequential cycle: flush pulse drops, counter holds
    @(negedge clk);
    applyStimulus(32'h0000_0084, 32'h0000_0082, 1'b0);
    #1;
    checkOutput("seqMis84", pcMis, 1'b0);
    tick();
    checkOutput("seqPcQ", pcQ, 32'h0000_0084);
    checkOutput("seqRedir", redirectQ, 1'b0);
    checkOutput("seqCntHold", redirectCount, 16'd6);
    checkOutput("seqSatHold", satRedirectCount, 2'd3);

    // Misaligned branch target
    @(negedge clk);
    pcSelect = 1'b1;
    #1;
    checkOutput("misOut", pcOut, 32'h0000_0082);
    checkOutput("misFlag", pcMis, 1'b1);
    tick();
    checkOutput("misPcQ", pcQ, 32'h0000_0082);
    checkOutput("misCnt", redirectCount, 16'd7);

    // Unknown select behaves as sequential and is not counted
    @(negedge clk);
    applyStimulus(32'h0000_0010, 32'h0000_0080, 1'bx);
    #1;
    checkOutput("xOut", pcOut, 32'h0000_0010);
    tick();
    checkOutput("xPcQ", pcQ, 32'h0000_0010);
    checkOutput("xRedir", redirectQ, 1'b0);
    checkOutput("xCnt", redirectCount, 16'd7);

    // Reset mid-operation wins over a branch, mux still follows inputs
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(32'h0000_0010, 32'h0000_0200, 1'b1);
    #1;
    checkOutput("midRstOut", pcOut, 32'h0000_0200);
    tick();
    checkOutput("midRstPcQ", pcQ, 32'h0000_0000);
    checkOutput("midRstRedir", redirectQ, 1'b0);
    checkOutput("midRstCnt", redirectCount, 16'd0);
    checkOutput("midRstSatCnt", satRedirectCount, 2'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
